// File: rtl/ssd_pkg.sv
// Shared constants and the hex-to-segment table for the seven-segment scan driver.
// Segment patterns are {g,f,e,d,c,b,a}, active low (common-anode board wiring).
package ssd_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Widest anode bank; narrower banks take the low slice.
    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

    typedef struct packed {
        logic [3:0] num;
        logic       dp;
        logic       blank;
        logic       blink;
    } digit_cfg_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        seg = SEG_OFF;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_seg_enc.sv
// Combinational 4-bit hex to active-low seven-segment decoder.
module ssd_seg_enc
    import ssd_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg(hex_i);

endmodule

// File: rtl/ssd_scan_mux.sv
// Time-multiplexed scan driver for NUM_DIGITS common-anode digits with blank,
// blink, decimal point and 8-level brightness; all outputs registered.
module ssd_scan_mux
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100_000,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4*NUM_DIGITS-1:0]       num_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         blank_in,
    input  logic [NUM_DIGITS-1:0]         blink_in,
    input  logic [2:0]                    bright_in,
    output logic [NUM_DIGITS-1:0]         an_out,
    output logic [6:0]                    cc_out,
    output logic                          dp_out,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_sel
);

    localparam int SEL_W   = $clog2(NUM_DIGITS);
    localparam int CNT_W   = $clog2(SCAN_DIV);
    localparam int SUB_DIV = SCAN_DIV / 8;
    localparam int SUB_W   = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam int BLK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SUB_W-1:0]      sub_cnt_q, sub_cnt_d;
    logic [2:0]            sub_q, sub_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [BLK_W-1:0]      blk_cnt_q, blk_cnt_d;
    logic                  blink_phase_q, blink_phase_d;

    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            cc_q, cc_d;
    logic                  dp_q, dp_d;
    logic [SEL_W-1:0]      dsel_q;

    digit_cfg_t            cur;
    logic [6:0]            cur_seg;
    logic                  digit_on;

    // Slot counter, brightness sub-phase and digit index.
    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        sub_cnt_d = sub_cnt_q + 1'b1;
        sub_d     = sub_q;
        sel_d     = sel_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            sub_cnt_d = '0;
            sub_d     = '0;
            sel_d     = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        end else if (sub_cnt_q == SUB_LAST) begin
            sub_cnt_d = '0;
            sub_d     = sub_q + 1'b1;
        end
    end

    always_comb begin
        blk_cnt_d     = blk_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
        if (blk_cnt_q == BLK_LAST) begin
            blk_cnt_d     = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    always_comb begin
        cur = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                cur.num   = num_in[4*i +: 4];
                cur.dp    = dp_in[i];
                cur.blank = blank_in[i];
                cur.blink = blink_in[i];
            end
        end
    end

    ssd_seg_enc u_seg_enc (
        .hex_i (cur.num),
        .seg_o (cur_seg)
    );

    // cnt_q != 0 keeps the anode dark for one cycle so the previous digit never ghosts.
    assign digit_on = (cnt_q != '0)
                   && (sub_q <= bright_in)
                   && !cur.blank
                   && !(cur.blink && !blink_phase_q);

    always_comb begin
        an_d = AN_OFF[NUM_DIGITS-1:0];
        cc_d = SEG_OFF;
        dp_d = 1'b1;
        if (digit_on) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel_q == SEL_W'(i)) begin
                    an_d[i] = 1'b0;
                end
            end
            cc_d = cur_seg;
            dp_d = ~cur.dp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            sub_cnt_q     <= '0;
            sub_q         <= '0;
            sel_q         <= '0;
            blk_cnt_q     <= '0;
            blink_phase_q <= 1'b1;
            an_q          <= AN_OFF[NUM_DIGITS-1:0];
            cc_q          <= SEG_OFF;
            dp_q          <= 1'b1;
            dsel_q        <= '0;
        end else begin
            cnt_q         <= cnt_d;
            sub_cnt_q     <= sub_cnt_d;
            sub_q         <= sub_d;
            sel_q         <= sel_d;
            blk_cnt_q     <= blk_cnt_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            cc_q          <= cc_d;
            dp_q          <= dp_d;
            dsel_q        <= sel_q;
        end
    end

    assign an_out    = an_q;
    assign cc_out    = cc_q;
    assign dp_out    = dp_q;
    assign digit_sel = dsel_q;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Directed bench for ssd_scan_mux: two instances (SCAN_DIV 8 and 16) share stimulus.
module tb_ssd_scan_mux;

    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] num_in;
    logic [3:0]  dp_in, blank_in, blink_in;
    logic [2:0]  bright_in;

    logic [3:0]  an8, an16;
    logic [6:0]  cc8, cc16;
    logic        dp8, dp16;
    logic [1:0]  sel8, sel16;

    int n_tests = 0;
    int n_fail  = 0;
    int j       = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    ssd_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(8), .BLINK_DIV(64)) dut (
        .clk(clk), .rst(rst), .num_in(num_in), .dp_in(dp_in), .blank_in(blank_in),
        .blink_in(blink_in), .bright_in(bright_in),
        .an_out(an8), .cc_out(cc8), .dp_out(dp8), .digit_sel(sel8)
    );

    ssd_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(16), .BLINK_DIV(64)) dut16 (
        .clk(clk), .rst(rst), .num_in(num_in), .dp_in(dp_in), .blank_in(blank_in),
        .blink_in(blink_in), .bright_in(bright_in),
        .an_out(an16), .cc_out(cc16), .dp_out(dp16), .digit_sel(sel16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // jj = cycles since reset release; the output after edge jj+1 reflects state jj.
    task automatic check_dut(input string tag, input int scan, input int jj,
                             input logic [3:0] an, input logic [6:0] cc,
                             input logic dp, input logic [1:0] sel);
        int         c, sub, dg;
        logic       ph, on;
        logic [3:0] ean;
        logic [6:0] ecc;
        logic       edp;
        c   = jj % scan;
        sub = c / (scan / 8);
        dg  = (jj / scan) % ND;
        ph  = ((jj / 64) % 2) == 0;
        on  = (c != 0) && (sub <= int'(bright_in)) && !blank_in[dg]
              && !(blink_in[dg] && !ph);
        ean = 4'hF;
        ecc = 7'h7F;
        edp = 1'b1;
        if (on) begin
            ean[dg] = 1'b0;
            ecc     = seg_tab[num_in[4*dg +: 4]];
            edp     = ~dp_in[dg];
        end
        check({tag, ".an"},  32'(an),  32'(ean));
        check({tag, ".cc"},  32'(cc),  32'(ecc));
        check({tag, ".dp"},  32'(dp),  32'(edp));
        check({tag, ".sel"}, 32'(sel), 32'(dg));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_dut("d8",  8,  j, an8,  cc8,  dp8,  sel8);
        check_dut("d16", 16, j, an16, cc16, dp16, sel16);
        j++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, ".an8"},   32'(an8),   32'h0000000F);
        check({tag, ".cc8"},   32'(cc8),   32'h0000007F);
        check({tag, ".dp8"},   32'(dp8),   32'h00000001);
        check({tag, ".sel8"},  32'(sel8),  32'h00000000);
        check({tag, ".an16"},  32'(an16),  32'h0000000F);
        check({tag, ".cc16"},  32'(cc16),  32'h0000007F);
        check({tag, ".dp16"},  32'(dp16),  32'h00000001);
        check({tag, ".sel16"}, 32'(sel16), 32'h00000000);
    endtask

    task automatic do_reset(input string tag, input int n);
        rst = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
            check_reset_outs(tag);
        end
        rst = 1'b0;
        j   = 0;
    endtask

    initial begin
        rst       = 1'b1;
        num_in    = 16'h4321;
        dp_in     = 4'b0000;
        blank_in  = 4'b0000;
        blink_in  = 4'b0000;
        bright_in = 3'd7;

        do_reset("rst", 3);
        run(40);

        num_in   = 16'hE5A7;
        blank_in = 4'b0100;
        dp_in    = 4'b0001;
        do_reset("rst_b", 1);
        run(32);

        num_in    = 16'hFD06;
        blank_in  = 4'b0000;
        dp_in     = 4'b1010;
        bright_in = 3'd0;
        do_reset("rst_br", 1);
        run(64);
        bright_in = 3'd3;
        run(64);
        bright_in = 3'd7;
        run(64);
        bright_in = 3'd2;
        run(9);
        bright_in = 3'd5;
        run(23);

        num_in    = 16'h9BC8;
        dp_in     = 4'b0000;
        bright_in = 3'd7;
        blink_in  = 4'b1000;
        do_reset("rst_bl", 1);
        run(256);

        blink_in = 4'b0000;
        blank_in = 4'b1111;
        run(24);

        blank_in = 4'b0000;
        num_in   = 16'h4321;
        do_reset("rst_m", 1);
        run(21);
        do_reset("rst_mid", 1);
        run(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
